// File: rtl/sseg_scan_ctrl_if.sv
// Bus bundle for the four-digit seven-segment scan controller.
// The master side supplies the value to display and the load strobe.
// The slave side (the controller) returns the scan outputs and status.
interface sseg_scan_ctrl_if;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        pending;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  modport master (
    output hex_in, dp_in, load,
    input  pending, an, sseg, frame_tick
  );

  modport slave (
    input  hex_in, dp_in, load,
    output pending, an, sseg, frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit, active-high seven-segment scan controller for the Mark1 board.
//
// Each digit owns a slot of 2^N clocks. The first BLANK_CYC clocks of every
// slot force all outputs low to suppress ghosting. A captured value waits in
// a shadow register and moves to the live display register only at a frame
// boundary, which is the end of digit 3's slot. This keeps any single frame
// from showing a mix of old and new digits.
//
// Optional build macro: SSEG_LZ_BLANK_EN enables leading-zero suppression.
// With it, digits 3..1 are blanked while they and every digit above them show
// 0 with no decimal point. Digit 0 is always drawn.

// Hex-to-seven-segment decoder, active-high, output ordered {a,b,c,d,e,f,g}.
module sseg_hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Combinational glyph lookup
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
  end
endmodule

module sseg_scan_ctrl #(
  parameter int N         = 18,
  parameter int BLANK_CYC = 1024
) (
  input logic         clk,
  input logic         reset,
  sseg_scan_ctrl_if.slave bus
);

  localparam logic [N-1:0] Q_ONE      = N'(1);
  localparam logic [N-1:0] BLANK_LIMIT = N'(BLANK_CYC);

  // Scan position: q counts within a slot, idx selects the digit.
  logic [N-1:0] q;
  logic [1:0]   idx;

  // {dp[3:0], hex[15:0]} for the waiting value and the value being scanned.
  logic [19:0]  shadow;
  logic [19:0]  display;
  logic         pending;

  logic [3:0]   an_reg;
  logic [7:0]   sseg_reg;
  logic         frame_tick_reg;

  logic         slot_end;
  logic         boundary;
  logic         in_blank;
  logic [3:0]   nib [4];
  logic [3:0]   disp_dp;
  logic [3:0]   cur_nib;
  logic         cur_dp;
  logic [6:0]   glyph;
  logic         digit_blank;

  assign slot_end = &q;
  assign boundary = slot_end && (idx == 2'd3);
  assign in_blank = (q < BLANK_LIMIT);

  // Split the live display value into per-digit nibbles.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = display[4*gi +: 4];
    end
  endgenerate

  assign disp_dp = display[19:16];
  assign cur_nib = nib[idx];
  assign cur_dp  = disp_dp[idx];

  sseg_hex_decoder u_dec (
    .hex (cur_nib),
    .seg (glyph)
  );

`ifdef SSEG_LZ_BLANK_EN
  // lz[k] is set when digit k and every digit above it are a bare zero.
  logic [3:0] lz;
  assign lz[3] = (nib[3] == 4'h0) && !disp_dp[3];
  generate
    for (gi = 1; gi < 3; gi++) begin : g_lz
      assign lz[gi] = lz[gi+1] && (nib[gi] == 4'h0) && !disp_dp[gi];
    end
  endgenerate
  assign lz[0] = 1'b0;
  assign digit_blank = lz[idx];
`else
  assign digit_blank = 1'b0;
`endif

  // Refresh counter and digit index; idx advances when a slot completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= '0;
      idx <= 2'd0;
    end else begin
      q <= q + Q_ONE;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Double buffer: loads park in shadow, and display changes only at a frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        shadow  <= {bus.dp_in, bus.hex_in};
        display <= {bus.dp_in, bus.hex_in};
        pending <= 1'b0;
      end else if (pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
    end else if (bus.load) begin
      shadow  <= {bus.dp_in, bus.hex_in};
      pending <= 1'b1;
    end
  end

  // Registered scan outputs, one clock behind (q, idx)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg         <= 4'b0000;
      sseg_reg       <= 8'h00;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= boundary;
      if (in_blank) begin
        an_reg   <= 4'b0000;
        sseg_reg <= 8'h00;
      end else begin
        an_reg   <= 4'b0001 << idx;
        sseg_reg <= digit_blank ? 8'h00 : {cur_dp, glyph};
      end
    end
  end

  assign bus.pending    = pending;
  assign bus.an         = an_reg;
  assign bus.sseg       = sseg_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl with N=4, BLANK_CYC=2
// (16-clock slots, 64-clock frames). A behavioural model derives the
// expected scan from the elapsed clock count since reset. It is
// cross-checked by a table of hand-decoded frames and by a few directed
// corner-case sequences. Build with SSEG_LZ_BLANK_EN defined to exercise
// leading-zero suppression.
module tb_sseg_scan_ctrl;
  localparam int N     = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(.N(N), .BLANK_CYC(BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cyc;
  logic [19:0] m_disp;
  logic [19:0] m_shad;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [7:0]  e_sseg;
  logic        e_tick;

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic [7:0] obs [4];

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [31:0] exp;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [6];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] model_digit(logic [19:0] v, int k);
    logic [3:0] h;
    logic       d;
    h = v[4*k +: 4];
    d = v[16+k];
`ifdef SSEG_LZ_BLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int j = 3; j > k; j--) begin
        if (v[4*j +: 4] != 4'h0 || v[16+j]) lead = 1'b0;
      end
      if (k != 0 && lead && h == 4'h0 && !d) return 8'h00;
    end
`endif
    return {d, glyph_tab[h]};
  endfunction

  task automatic model_reset();
    cyc    = 0;
    m_disp = '0;
    m_shad = '0;
    m_pend = 1'b0;
    e_an   = 4'b0000;
    e_sseg = 8'h00;
    e_tick = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge
  task automatic model_edge();
    int off;
    int slot;
    bit bnd;
    off  = cyc % SLOT;
    slot = (cyc / SLOT) % 4;
    bnd  = (cyc % FRAME) == FRAME - 1;
    e_an   = (off < BLANK) ? 4'b0000 : 4'(1 << slot);
    e_sseg = (off < BLANK) ? 8'h00 : model_digit(m_disp, slot);
    e_tick = bnd;
    if (bnd) begin
      if (bus.load) begin
        m_disp = {bus.dp_in, bus.hex_in};
        m_shad = m_disp;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_disp = m_shad;
        m_pend = 1'b0;
      end
    end else if (bus.load) begin
      m_shad = {bus.dp_in, bus.hex_in};
      m_pend = 1'b1;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("an", bus.an, e_an);
    check("sseg", bus.sseg, e_sseg);
    check("pending", bus.pending, m_pend);
    check("frame_tick", bus.frame_tick, e_tick);
  endtask

  task automatic do_load(logic [15:0] h, logic [3:0] d);
    $display("load hex=%04h dp=%04b at pos %0d", h, d, cyc % FRAME);
    bus.hex_in = h;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
  endtask

  task automatic wait_pos(int p);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((cyc % FRAME) == p) return;
      tick();
    end
    check("wait_pos", 32'(cyc % FRAME), 32'(p));
  endtask

  // Record the glyph driven for each digit over one whole frame
  task automatic capture_frame();
    for (int k = 0; k < 4; k++) obs[k] = 8'hxx;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (bus.an == 4'(1 << k)) obs[k] = bus.sseg;
      end
    end
  endtask

  task automatic check_frame(string nm, logic [31:0] exp);
    for (int k = 0; k < 4; k++) check(nm, {24'h0, obs[k]}, {24'h0, exp[8*k +: 8]});
    $display("frame %s: d3=%02h d2=%02h d1=%02h d0=%02h", nm, obs[3], obs[2], obs[1], obs[0]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("rst_an", bus.an, 4'b0000);
    check("rst_sseg", bus.sseg, 8'h00);
    check("rst_pending", bus.pending, 1'b0);
    check("rst_frame_tick", bus.frame_tick, 1'b0);
    #4 reset = 1'b0;
    $display("async reset mid-frame applied and released");
  endtask

  task automatic check_restart();
    tick(); check("restart_blank1", bus.an, 4'b0000);
    tick(); check("restart_blank2", bus.an, 4'b0000);
    tick(); check("restart_an", bus.an, 4'b0001);
    check("restart_sseg", bus.sseg, 8'h7E);
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 32'h30ED7747};
    vecs[1] = '{16'h8888, 4'b1111, 32'hFFFFFFFF};
    vecs[2] = '{16'h0050, 4'b1000, 32'hFE7E5B7E};
`ifdef SSEG_LZ_BLANK_EN
    vecs[3] = '{16'h0050, 4'b0000, 32'h00005B7E};
    vecs[4] = '{16'h0000, 4'b0000, 32'h0000007E};
    vecs[5] = '{16'h0007, 4'b0010, 32'h0000FE70};
`else
    vecs[3] = '{16'h0050, 4'b0000, 32'h7E7E5B7E};
    vecs[4] = '{16'h0000, 4'b0000, 32'h7E7E7E7E};
    vecs[5] = '{16'h0007, 4'b0010, 32'h7E7EFE70};
`endif

    bus.hex_in = '0;
    bus.dp_in  = '0;
    bus.load   = 1'b0;
    model_reset();
    #12 reset = 1'b0;
    #1;
    check("reset_an", bus.an, 4'b0000);
    check("reset_sseg", bus.sseg, 8'h00);
    check("reset_pending", bus.pending, 1'b0);
    check("reset_frame_tick", bus.frame_tick, 1'b0);
    $display("reset released");
    check_restart();

    // Table of mid-frame loads, each decoded by hand
    for (int v = 0; v < 6; v++) begin
      wait_pos(20);
      do_load(vecs[v].hex, vecs[v].dp);
      check("pend_set", bus.pending, 1'b1);
      wait_pos(0);
      check("pend_clear", bus.pending, 1'b0);
      capture_frame();
      check_frame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Two loads in one frame: only the last reaches the display
    wait_pos(10);
    do_load(16'h1111, 4'b0000);
    wait_pos(40);
    do_load(16'h2222, 4'b0000);
    wait_pos(0);
    capture_frame();
    check_frame("last_wins", 32'h6D6D6D6D);

    // Load on the boundary cycle goes straight to the display
    wait_pos(FRAME - 1);
    do_load(16'h00C3, 4'b0000);
    check("bnd_pending", bus.pending, 1'b0);
    capture_frame();
`ifdef SSEG_LZ_BLANK_EN
    check_frame("bnd_load", 32'h00004E79);
`else
    check_frame("bnd_load", 32'h7E7E4E79);
`endif

    // Async reset mid-frame discards a pending load
    wait_pos(30);
    do_load(16'hBEEF, 4'b1111);
    check("pend_before_rst", bus.pending, 1'b1);
    do_reset();
    check_restart();

    // Randomized loads checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_load(16'($urandom), 4'($urandom));
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
